// File: rtl/axis_pkg.sv
// Shared types and defaults for the camera entry-dump stream transmitter.
package axis_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dump_state_t;

  // A new read may issue only if it is guaranteed a free buffer slot when its data returns.
  function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
    logic [2:0] pend;
    pend = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    return pend < 3'd2;
  endfunction

endpackage

// File: rtl/axis_skid_buf2.sv
// Two-entry in-order buffer; head entry stays put until popped.
module axis_skid_buf2
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_last,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] slot0_data, slot1_data;
  logic                  slot0_last, slot1_last;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot0_data <= '0;
      slot1_data <= '0;
      slot0_last <= 1'b0;
      slot1_last <= 1'b0;
      occ        <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            slot0_data <= push_data;
            slot0_last <= push_last;
          end else begin
            slot1_data <= push_data;
            slot1_last <= push_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0_data <= slot1_data;
          slot0_last <= slot1_last;
          occ        <= occ - 2'd1;
        end
        // Simultaneous push/pop: occupancy unchanged, new entry lands behind the survivor.
        2'b11: begin
          if (occ == 2'd1) begin
            slot0_data <= push_data;
            slot0_last <= push_last;
          end else begin
            slot0_data <= slot1_data;
            slot0_last <= slot1_last;
            slot1_data <= push_data;
            slot1_last <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid     = (occ != 2'd0);
  assign head_data = slot0_data;
  assign head_last = slot0_last & valid;

endmodule

// File: rtl/axis_cam_dump_tx.sv
// Streams entries 0..count-1 from a one-cycle-latency RAM out over AXI-Stream,
// marking the final beat with tlast and pulsing done afterwards.
module axis_cam_dump_tx
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  dump_state_t         state, state_nxt;
  logic [ADDR_WIDTH:0] cnt_q;
  logic                rd_vld_p1, rd_last_p1;
  logic                pop, rd_is_last;
  logic [1:0]          occ;

  assign pop        = m_axis_tvalid & m_axis_tready;
  assign rd_is_last = ({1'b0, rd_addr} == (cnt_q - CNT_ONE));

  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DONE : ST_READ;
      ST_READ:  if (rd_en && rd_is_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (pop && m_axis_tlast) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != ST_IDLE);
    done  = (state == ST_DONE);
    rd_en = (state == ST_READ) && credit_ok(occ, rd_vld_p1, pop);
  end

  // Read issue -> data return (p1): rd_data is valid the cycle after rd_en.
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      cnt_q      <= '0;
      rd_addr    <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        cnt_q   <= count;
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + ADDR_ONE;
      end
      rd_vld_p1  <= rd_en;
      rd_last_p1 <= rd_en & rd_is_last;
    end
  end

  axis_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
    .clk       (m_axis_aclk),
    .rstn      (m_axis_aresetn),
    .push      (rd_vld_p1),
    .push_data (rd_data),
    .push_last (rd_last_p1),
    .pop       (pop),
    .valid     (m_axis_tvalid),
    .head_data (m_axis_tdata),
    .head_last (m_axis_tlast),
    .occ       (occ)
  );

endmodule

// File: tb/tb_axis_cam_dump_tx.sv
// Directed bench for axis_cam_dump_tx with a one-cycle-latency RAM model (RAM[i] = 0xA0 + i).
module tb_axis_cam_dump_tx;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW:0]   count;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast;

  int n_cmp = 0;
  int n_bad = 0;

  axis_cam_dump_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rstn),
    .start          (start),
    .count          (count),
    .busy           (busy),
    .done           (done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .m_axis_tdata   (tdata),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .m_axis_tlast   (tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= 32'hA0 + 32'(rd_addr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},   busy,    0);
    chk({tag, "_done"},   done,    0);
    chk({tag, "_rd_en"},  rd_en,   0);
    chk({tag, "_tvalid"}, tvalid,  0);
    chk({tag, "_tlast"},  tlast,   0);
    chk({tag, "_rdaddr"}, rd_addr, 0);
    chk({tag, "_tdata"},  tdata,   0);
  endtask

  // Cycle 0 is the start cycle; all cycle numbers returned are relative to it.
  task automatic run_dump(input int cnt, input bit toggle, input int restart_cyc, input int abort_beats,
                          output int first_rd, output int first_vld, output int last_cyc,
                          output int done_cyc, output int n_beats, output int n_reads);
    int beat, nrd;
    bit stalled, aborting;
    logic [DW-1:0] held;
    beat = 0; nrd = 0; stalled = 0; aborting = 0; held = '0;
    first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
    @(negedge clk);
    start = 1'b1; count = (AW+1)'(cnt); tready = 1'b1;
    for (int c = 1; c < 2000; c++) begin
      @(negedge clk);
      start  = (c == restart_cyc);
      count  = (c == restart_cyc) ? (AW+1)'(5) : (AW+1)'(cnt);
      tready = toggle ? c[0] : 1'b1;
      if (aborting) begin
        #1;
        chk_idle_outputs("abort");
        rstn = 1'b1;
        break;
      end
      if (abort_beats > 0 && beat == abort_beats) begin
        rstn = 1'b0;
        aborting = 1;
        continue;
      end
      #1;
      if (stalled) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, held);
      end
      stalled = tvalid & ~tready;
      held = tdata;
      if (rd_en) begin
        if (first_rd < 0) first_rd = c;
        chk("rd_addr", rd_addr, nrd[AW-1:0]);
        nrd++;
      end
      if (tvalid && first_vld < 0) first_vld = c;
      if (!toggle && first_vld >= 0 && beat < cnt) chk("no_bubble", tvalid, 1);
      if (tvalid && tready) begin
        chk("tdata", tdata, 32'hA0 + beat);
        chk("tlast", tlast, (beat == cnt - 1));
        if (tlast) last_cyc = c;
        beat++;
      end
      chk("occ_le2", (dut.u_buf.occ <= 2'd2), 1);
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0;
    tready = 1'b1;
    n_beats = beat;
    n_reads = nrd;
  endtask

  initial begin
    int fr, fv, lc, dc, nb, nr;
    rstn = 1'b0; start = 1'b0; count = '0; tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_idle_outputs("reset");
    rstn = 1'b1;

    // count=4, tready high
    run_dump(4, 0, -1, 0, fr, fv, lc, dc, nb, nr);
    chk("c4_first_rd", fr, 1);
    chk("c4_first_vld", fv, 3);
    chk("c4_last_cyc", lc, 6);
    chk("c4_done_cyc", dc, 7);
    chk("c4_beats", nb, 4);
    chk("c4_reads", nr, 4);

    // count=8, tready toggling
    run_dump(8, 1, -1, 0, fr, fv, lc, dc, nb, nr);
    chk("c8t_beats", nb, 8);
    chk("c8t_reads", nr, 8);
    chk("c8t_done_seen", (dc > 0), 1);
    chk("c8t_first_vld", fv, 3);

    // count=0
    run_dump(0, 0, -1, 0, fr, fv, lc, dc, nb, nr);
    chk("c0_done_cyc", dc, 1);
    chk("c0_first_rd", fr, -1);
    chk("c0_first_vld", fv, -1);
    chk("c0_beats", nb, 0);

    // count=256, full address space
    run_dump(256, 0, -1, 0, fr, fv, lc, dc, nb, nr);
    chk("c256_first_vld", fv, 3);
    chk("c256_last_cyc", lc, 258);
    chk("c256_done_cyc", dc, 259);
    chk("c256_beats", nb, 256);
    chk("c256_reads", nr, 256);

    // second start while busy is ignored
    run_dump(4, 0, 2, 0, fr, fv, lc, dc, nb, nr);
    chk("rs_beats", nb, 4);
    chk("rs_reads", nr, 4);
    chk("rs_done_cyc", dc, 7);

    // reset after beat 2 of a count-6 dump
    run_dump(6, 0, -1, 3, fr, fv, lc, dc, nb, nr);
    chk("ab_beats", nb, 3);
    chk("ab_no_done", dc, -1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("ab_idle_done", done, 0);
      chk("ab_idle_busy", busy, 0);
    end
    run_dump(3, 0, -1, 0, fr, fv, lc, dc, nb, nr);
    chk("c3_first_rd", fr, 1);
    chk("c3_first_vld", fv, 3);
    chk("c3_last_cyc", lc, 5);
    chk("c3_done_cyc", dc, 6);
    chk("c3_beats", nb, 3);
    chk("c3_reads", nr, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
